// File: rtl/wb_sdr_traffic_gen.sv
// wb_sdr_traffic_gen: Wishbone burst traffic generator / checker for sdrc_top.
// The generator writes cfg_num_bursts bursts from cfg_base_addr and then reads
// them back, comparing each read beat against a regenerated data stream.
// Optional ack watchdog: define WB_SDR_TRAFFIC_GEN_TIMEOUT_EN.
//
// Handshake: a beat is transferred on a clock edge where wb_stb_o=1 and
// wb_ack_i=1; address, data and beat counters advance only on such edges,
// and cyc/stb drop for exactly one cycle after the final beat of each burst.
module wb_sdr_traffic_gen #(
  parameter int APP_AW      = 26,
  parameter int WB_DW       = 32,
  parameter int BURST_MAX   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 sys_clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 sdr_init_done,
  input  logic [APP_AW-1:0]    cfg_base_addr,
  input  logic [15:0]          cfg_num_bursts,
  input  logic [4:0]           cfg_bl,
  input  logic                 cfg_mode,
  input  logic [WB_DW-1:0]     cfg_seed,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [APP_AW-1:0]    wb_addr_o,
  output logic [WB_DW-1:0]     wb_dat_o,
  output logic [WB_DW/8-1:0]   wb_sel_o,
  output logic [2:0]           wb_cti_o,
  input  logic                 wb_ack_i,
  input  logic [WB_DW-1:0]     wb_dat_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_cnt,
  output logic [APP_AW-1:0]    first_err_addr,
  output logic                 timeout,
  output logic [2:0]           dbg_state_o
);

`ifdef WB_SDR_TRAFFIC_GEN_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam int BPB = WB_DW / 8;

  typedef enum logic [2:0] {IDLE, WAIT_INIT, WR, RD, FIN} state_t;

  state_t              state_q, state_d;
  logic                stb_q, stb_d;
  logic [APP_AW-1:0]   addr_q, addr_d, base_q, base_d;
  logic [WB_DW-1:0]    dat_q, dat_d, seed_q, seed_d;
  logic [15:0]         nb_q, nb_d, burst_q, burst_d;
  logic [4:0]          bl_q, bl_d, beat_q, beat_d, bl_eff;
  logic                mode_q, mode_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]         err_q, err_d;
  logic [APP_AW-1:0]   ferr_q, ferr_d;
  logic                tmo_q, tmo_d;
  logic [WDW-1:0]      wd_q, wd_d;
  logic                last_beat, last_burst;

  // One Galois step of x^32+x^22+x^2+x+1 on the low word, replicated upward.
  function automatic logic [WB_DW-1:0] lfsr_next(input logic [WB_DW-1:0] cur);
    logic [31:0] s;
    s = cur[31:0];
    s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    return {(WB_DW/32){s}};
  endfunction

  // First data word of a phase; the LFSR cannot start from zero.
  function automatic logic [WB_DW-1:0] seed_init(input logic mode, input logic [WB_DW-1:0] seed);
    logic [31:0] s;
    s = seed[31:0];
    if (s == 32'd0) s = 32'd1;
    return mode ? {(WB_DW/32){s}} : seed;
  endfunction

  // Clamp the requested burst length into 1..BURST_MAX.
  always_comb begin
    bl_eff = cfg_bl;
    if (cfg_bl == 5'd0) bl_eff = 5'd1;
    else if (cfg_bl > 5'(BURST_MAX)) bl_eff = 5'(BURST_MAX);
  end

  assign last_beat  = (beat_q == bl_q - 5'd1);
  assign last_burst = (burst_q == nb_q - 16'd1);

  // Next-state logic: phase sequencing, beat/burst counting and read compare.
  always_comb begin
    state_d = state_q;  stb_d  = stb_q;  addr_d = addr_q;  base_d = base_q;
    dat_d   = dat_q;    seed_d = seed_q; nb_d   = nb_q;    burst_d = burst_q;
    bl_d    = bl_q;     beat_d = beat_q; mode_d = mode_q;
    busy_d  = busy_q;   done_d = done_q; pass_d = pass_q;
    err_d   = err_q;    ferr_d = ferr_q; tmo_d  = tmo_q;
    wd_d    = (stb_q && !wb_ack_i) ? wd_q + WDW'(1) : '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_INIT;
          busy_d  = 1'b1;  done_d = 1'b0;  pass_d = 1'b0;
          err_d   = '0;    ferr_d = '0;    tmo_d  = 1'b0;
          base_d  = cfg_base_addr;  nb_d = cfg_num_bursts;
          bl_d    = bl_eff;         mode_d = cfg_mode;  seed_d = cfg_seed;
          addr_d  = cfg_base_addr;  dat_d = seed_init(cfg_mode, cfg_seed);
          beat_d  = '0;             burst_d = '0;
        end
      end
      WAIT_INIT: begin
        if (sdr_init_done) begin
          if (nb_q == 16'd0) begin
            state_d = FIN;  busy_d = 1'b0;  done_d = 1'b1;  pass_d = 1'b1;
          end else begin
            state_d = WR;   stb_d = 1'b1;
          end
        end
      end
      WR, RD: begin
        if (!stb_q) begin
          stb_d = 1'b1;
        end else if (wb_ack_i) begin
          addr_d = addr_q + APP_AW'(BPB);
          dat_d  = mode_q ? lfsr_next(dat_q) : dat_q + WB_DW'(1);
          beat_d = beat_q + 5'd1;
          if (state_q == RD && wb_dat_i != dat_q) begin
            if (err_q == 16'd0) ferr_d = addr_q;
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          end
          if (last_beat) begin
            stb_d   = 1'b0;
            beat_d  = '0;
            burst_d = burst_q + 16'd1;
            if (last_burst) begin
              burst_d = '0;
              if (state_q == WR) begin
                state_d = RD;
                addr_d  = base_q;
                dat_d   = seed_init(mode_q, seed_q);
              end else begin
                state_d = FIN;  busy_d = 1'b0;  done_d = 1'b1;
                pass_d  = (err_d == 16'd0);
              end
            end
          end
        end else if (WD_EN && wd_q == WDW'(TIMEOUT_CYC - 1)) begin
          stb_d   = 1'b0;  wd_d = '0;  tmo_d = 1'b1;
          state_d = FIN;   busy_d = 1'b0;  done_d = 1'b1;  pass_d = 1'b0;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops the bus strobes immediately.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;  stb_q <= 1'b0;  addr_q <= '0;  base_q <= '0;
      dat_q   <= '0;    seed_q <= '0;   nb_q <= '0;    burst_q <= '0;
      bl_q    <= '0;    beat_q <= '0;   mode_q <= 1'b0;
      busy_q  <= 1'b0;  done_q <= 1'b0; pass_q <= 1'b0;
      err_q   <= '0;    ferr_q <= '0;   tmo_q <= 1'b0;  wd_q <= '0;
    end else begin
      state_q <= state_d;  stb_q <= stb_d;  addr_q <= addr_d;  base_q <= base_d;
      dat_q   <= dat_d;    seed_q <= seed_d; nb_q <= nb_d;     burst_q <= burst_d;
      bl_q    <= bl_d;     beat_q <= beat_d; mode_q <= mode_d;
      busy_q  <= busy_d;   done_q <= done_d; pass_q <= pass_d;
      err_q   <= err_d;    ferr_q <= ferr_d; tmo_q <= tmo_d;   wd_q <= wd_d;
    end
  end

  assign wb_cyc_o       = stb_q;
  assign wb_stb_o       = stb_q;
  assign wb_we_o        = stb_q && (state_q == WR);
  assign wb_addr_o      = addr_q;
  assign wb_dat_o       = dat_q;
  assign wb_sel_o       = '1;
  assign wb_cti_o       = !stb_q ? 3'b000 : (last_beat ? 3'b111 : 3'b010);
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_q;
  assign timeout        = WD_EN ? tmo_q : 1'b0;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_wb_sdr_traffic_gen.sv
// Bench for wb_sdr_traffic_gen: a memory model acks strobes with random stalls;
// expected beats are queued by the driver and popped by the memory monitor.
module tb_wb_sdr_traffic_gen;
  localparam int AW = 26;
  localparam int DW = 32;

  logic          sys_clk = 1'b0, resetn = 1'b0, start = 1'b0, sdr_init_done = 1'b1;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [15:0]   cfg_num_bursts = '0;
  logic [4:0]    cfg_bl = '0;
  logic          cfg_mode = 1'b0;
  logic [DW-1:0] cfg_seed = '0;
  logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i = 1'b0;
  logic [AW-1:0] wb_addr_o, first_err_addr;
  logic [DW-1:0] wb_dat_o, wb_dat_i = '0;
  logic [3:0]    wb_sel_o;
  logic [2:0]    wb_cti_o, dbg_state_o;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_cnt;

  // Scoreboard entry: {we, cti, addr, data}
  logic [1+3+AW+DW-1:0] exp_q[$];
  logic [DW-1:0]        mem [logic [AW-1:0]];
  int                   total = 0, bad = 0;
  logic                 corrupt_en = 1'b0, stall_all = 1'b0, gap_pend = 1'b0;
  logic [AW-1:0]        corrupt_addr = '0;

  wb_sdr_traffic_gen #(.APP_AW(AW), .WB_DW(DW), .BURST_MAX(8), .TIMEOUT_CYC(16)) dut (
    .sys_clk(sys_clk), .resetn(resetn), .start(start), .sdr_init_done(sdr_init_done),
    .cfg_base_addr(cfg_base_addr), .cfg_num_bursts(cfg_num_bursts), .cfg_bl(cfg_bl),
    .cfg_mode(cfg_mode), .cfg_seed(cfg_seed), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i), .busy(busy),
    .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .timeout(timeout), .dbg_state_o(dbg_state_o));

  // Clock
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Memory model + monitor: acks on the falling edge, checks every acked beat.
  always @(negedge sys_clk) begin
    logic [1+3+AW+DW-1:0] e;
    logic [DW-1:0]        rd;
    if (!resetn) begin
      wb_ack_i = 1'b0;
      gap_pend = 1'b0;
    end else begin
      if (gap_pend) begin
        check("burst_gap", {63'd0, wb_stb_o}, 64'd0);
        gap_pend = 1'b0;
      end
      if (wb_stb_o && !stall_all && $urandom_range(0, 3) != 0) begin
        wb_ack_i = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {38'd0, wb_addr_o}, 64'h0BAD);
        end else begin
          e = exp_q.pop_front();
          check("beat_we",   {63'd0, wb_we_o},   {63'd0, e[61]});
          check("beat_cti",  {61'd0, wb_cti_o},  {61'd0, e[60:58]});
          check("beat_addr", {38'd0, wb_addr_o}, {38'd0, e[57:32]});
          if (e[61]) check("beat_wdata", {32'd0, wb_dat_o}, {32'd0, e[31:0]});
        end
        if (wb_we_o) begin
          mem[wb_addr_o] = wb_dat_o;
        end else begin
          rd = mem.exists(wb_addr_o) ? mem[wb_addr_o] : '0;
          if (corrupt_en && wb_addr_o == corrupt_addr) rd = rd ^ 32'h1;
          wb_dat_i = rd;
        end
        gap_pend = (wb_cti_o == 3'b111);
      end else begin
        wb_ack_i = 1'b0;
      end
    end
  end

  // Push the full write+read beat stream for one run.
  task automatic push_model(input logic [AW-1:0] base, input logic [15:0] nb,
                            input logic [4:0] bl, input logic mode, input logic [31:0] seed);
    int ebl, n;
    logic [31:0] d;
    logic [AW-1:0] a;
    ebl = (bl == 0) ? 1 : (bl > 8) ? 8 : int'(bl);
    for (int ph = 0; ph < 2; ph++) begin
      n = 0;
      d = (mode && seed == 0) ? 32'd1 : seed;
      for (int b = 0; b < int'(nb); b++) begin
        for (int k = 0; k < ebl; k++) begin
          a = base + AW'(n * 4);
          exp_q.push_back({(ph == 0), (k == ebl - 1) ? 3'b111 : 3'b010, a, d});
          d = mode ? lfsr_step(d) : d + 32'd1;
          n++;
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 20000 && !done; i++) @(negedge sys_clk);
    check({tag, "_done"}, {63'd0, done}, 64'd1);
  endtask

  task automatic run(input string tag, input logic [AW-1:0] base, input logic [15:0] nb,
                     input logic [4:0] bl, input logic mode, input logic [31:0] seed,
                     input logic [15:0] e_err, input logic [AW-1:0] e_first, input logic e_pass);
    push_model(base, nb, bl, mode, seed);
    cfg_base_addr = base; cfg_num_bursts = nb; cfg_bl = bl; cfg_mode = mode; cfg_seed = seed;
    pulse_start();
    check({tag, "_busy_after_start"}, {63'd0, busy}, 64'd1);
    check({tag, "_done_after_start"}, {63'd0, done}, 64'd0);
    // Later config changes and a stray start must not disturb the run.
    cfg_base_addr = 26'h155_5550; cfg_num_bursts = 16'd7; cfg_bl = 5'd3; cfg_mode = ~mode;
    cfg_seed = 32'hDEAD_BEEF;
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    wait_done(tag);
    check({tag, "_pass"},      {63'd0, pass},           {63'd0, e_pass});
    check({tag, "_err_cnt"},   {48'd0, err_cnt},        {48'd0, e_err});
    check({tag, "_first_err"}, {38'd0, first_err_addr}, {38'd0, e_first});
    check({tag, "_busy_end"},  {63'd0, busy},           64'd0);
    check({tag, "_timeout"},   {63'd0, timeout},        64'd0);
    check({tag, "_queue_left"}, 64'(exp_q.size()),      64'd0);
    @(negedge sys_clk);
  endtask

  initial begin
    int viol;
    // Reset
    repeat (3) @(negedge sys_clk);
    check("rst_cyc",   {63'd0, wb_cyc_o}, 64'd0);
    check("rst_stb",   {63'd0, wb_stb_o}, 64'd0);
    check("rst_cti",   {61'd0, wb_cti_o}, 64'd0);
    check("rst_sel",   {60'd0, wb_sel_o}, 64'hF);
    check("rst_busy",  {62'd0, busy, done}, 64'd0);
    check("rst_state", {61'd0, dbg_state_o}, 64'd0);
    resetn = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Basic incrementing run, then the same with a corrupted read at 0x110
    run("inc", 26'h100, 16'd4, 5'd8, 1'b0, 32'hA5A5_0000, 16'd0, 26'h0, 1'b1);
    corrupt_en = 1'b1; corrupt_addr = 26'h110;
    run("corrupt", 26'h100, 16'd4, 5'd8, 1'b0, 32'hA5A5_0000, 16'd1, 26'h110, 1'b0);
    corrupt_en = 1'b0;

    // Burst length clamps, wrap with LFSR from seed 0, empty run
    run("bl0",  26'h200, 16'd3, 5'd0,  1'b0, 32'h0000_0011, 16'd0, 26'h0, 1'b1);
    run("bl20", 26'h400, 16'd2, 5'd20, 1'b0, 32'hFFFF_FFFE, 16'd0, 26'h0, 1'b1);
    run("wrap", 26'h3FF_FFF8, 16'd2, 5'd4, 1'b1, 32'h0, 16'd0, 26'h0, 1'b1);
    run("nb0",  26'h600, 16'd0, 5'd4, 1'b0, 32'h5, 16'd0, 26'h0, 1'b1);

    // Init wait: no traffic while sdr_init_done is low
    sdr_init_done = 1'b0;
    push_model(26'h800, 16'd1, 5'd2, 1'b0, 32'h77);
    cfg_base_addr = 26'h800; cfg_num_bursts = 16'd1; cfg_bl = 5'd2; cfg_mode = 1'b0; cfg_seed = 32'h77;
    pulse_start();
    viol = 0;
    for (int i = 0; i < 500; i++) begin
      if (wb_cyc_o !== 1'b0 || busy !== 1'b1) viol++;
      @(negedge sys_clk);
    end
    check("init_hold_violations", 64'(viol), 64'd0);
    sdr_init_done = 1'b1;
    @(negedge sys_clk);
    check("init_traffic_starts", {63'd0, wb_cyc_o}, 64'd1);
    wait_done("init");
    check("init_pass", {63'd0, pass}, 64'd1);
    @(negedge sys_clk);

`ifdef WB_SDR_TRAFFIC_GEN_TIMEOUT_EN
    // Watchdog: memory never acks
    stall_all = 1'b1;
    cfg_base_addr = 26'h900; cfg_num_bursts = 16'd1; cfg_bl = 5'd4; cfg_mode = 1'b0; cfg_seed = 32'h0;
    pulse_start();
    wait_done("wd");
    check("wd_timeout", {63'd0, timeout}, 64'd1);
    check("wd_pass",    {63'd0, pass},    64'd0);
    check("wd_cyc",     {63'd0, wb_cyc_o}, 64'd0);
    stall_all = 1'b0;
    @(negedge sys_clk);
    run("wd_recover", 26'h900, 16'd1, 5'd4, 1'b0, 32'h0, 16'd0, 26'h0, 1'b1);
`endif

    // Reset in the middle of a run aborts it at once
    push_model(26'hA00, 16'd4, 5'd8, 1'b0, 32'h1);
    cfg_base_addr = 26'hA00; cfg_num_bursts = 16'd4; cfg_bl = 5'd8; cfg_mode = 1'b0; cfg_seed = 32'h1;
    pulse_start();
    viol = 0;
    for (int i = 0; i < 200 && !wb_stb_o; i++) @(negedge sys_clk);
    check("midrst_strobe_seen", {63'd0, wb_stb_o}, 64'd1);
    @(posedge sys_clk); #2;
    resetn = 1'b0;
    #1;
    check("midrst_cyc",  {63'd0, wb_cyc_o}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    exp_q.delete();
    @(negedge sys_clk); resetn = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("midrst_state", {61'd0, dbg_state_o}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_sdr_traffic_gen.md
Name: wb_sdr_traffic_gen

Overview:
- Synthesizable, self-checking Wishbone master traffic generator for sdrc_top.
- Writes a programmable region of SDRAM in bursts, reads it back and compares against a regenerated expected stream.
- Generalises fixed bench stimulus: configurable data width, burst length, region size and data mode.
- Sits between a bench/CPU control interface and the sdrc_top wb_* port group.

Parameters:
APP_AW, 26, Wishbone byte-address width
WB_DW, 32, Wishbone data width (32 or 64); WB_DW/8 = bytes per beat
BURST_MAX, 8, maximum beats per burst (power of 2, 1..16)
TIMEOUT_CYC, 1024, ack watchdog limit (used only with the optional feature)

Ports:
sys_clk  in  1  system/Wishbone clock
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; launches a run when idle
sdr_init_done  in  1  controller init complete
cfg_base_addr  in  APP_AW  start byte address, beat-aligned
cfg_num_bursts  in  16  number of bursts per phase
cfg_bl  in  5  beats per burst
cfg_mode  in  1  0 = incrementing data, 1 = LFSR data
cfg_seed  in  WB_DW  data seed
wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone controls
wb_addr_o  out  APP_AW  byte address
wb_dat_o  out  WB_DW  write data
wb_sel_o  out  WB_DW/8  byte enables, always all ones
wb_cti_o  out  3  cycle type
wb_ack_i  in  1  ack
wb_dat_i  in  WB_DW  read data
busy  out  1  run in progress
done  out  1  run finished; held until next accepted start
pass  out  1  valid when done; 1 = zero mismatches
err_cnt  out  16  saturating mismatch count
first_err_addr  out  APP_AW  address of first mismatch
timeout  out  1  watchdog abort flag

Behaviour:
- Reset: all outputs 0. Exception: wb_sel_o is all ones. The FSM returns to IDLE.
- Reset asserted mid-run aborts the run immediately. Wishbone strobes drop asynchronously.
- FSM states: IDLE, WAIT_INIT, WR, RD, FIN.
  - IDLE: start accepted. busy=1 and done=0 from the next cycle. Go to WAIT_INIT.
  - start while busy is ignored.
  - WAIT_INIT: hold until sdr_init_done=1, then go to WR.
  - WR: issue cfg_num_bursts bursts with we=1. When the last write beat is acked, go to RD.
  - RD: issue the same bursts with we=0. When the last read beat is acked, go to FIN.
  - FIN: one cycle. busy=0, done=1, pass=(err_cnt==0). Return to IDLE.
- cfg_num_bursts=0: go WAIT_INIT -> FIN with no bus traffic; pass=1.
- Burst length: effective BL = max(1, min(cfg_bl, BURST_MAX)). Config is sampled at start; later changes are ignored until the next run.
- Burst handshake:
  - cyc and stb assert together and stay high for all beats of a burst.
  - Advance to the next beat only on a cycle where stb=1 and ack=1. Address and data then update in the same cycle.
  - cyc and stb deassert for exactly one cycle between bursts.
- Cycle type: 3'b010 on non-final beats, 3'b111 on the final beat. A BL=1 burst uses 3'b111 only.
- Address: cfg_base_addr + n*(WB_DW/8), where n is the global beat index. Wraps modulo 2^APP_AW. The read phase restarts at cfg_base_addr.
- Data generation:
  - Mode 0: data = cfg_seed + n, modulo 2^WB_DW.
  - Mode 1: Galois LFSR, taps for x^32+x^22+x^2+x+1 applied to the low 32 bits, upper bits replicated. A seed of 0 is replaced by 1. Advance once per acked beat.
  - The generator is re-seeded at RD entry, so the expected stream equals the written stream.
- Compare: on each read ack, compare wb_dat_i against the expected value.
  - On mismatch, err_cnt increments, saturating at 16'hFFFF.
  - On the first mismatch only, first_err_addr captures wb_addr_o.
- err_cnt, first_err_addr and timeout clear on accepted start.

Optional Feature:
WB_SDR_TRAFFIC_GEN_TIMEOUT_EN
- Defined: a counter runs while stb=1 and ack=0, and clears on ack.
  - On reaching TIMEOUT_CYC it drops cyc/stb, sets timeout=1 and goes to FIN with pass=0.
- Undefined: no watchdog; the block waits for ack indefinitely. timeout is tied to 0.

Test Plan:
- Base 0x100, 4 bursts, BL=8, mode 0, seed 0xA5A50000, ideal memory -> 32 writes then 32 reads at 0x100..0x17C; data 0xA5A50000..0xA5A5001F; cti pattern 010x7,111; done=1, pass=1, err_cnt=0.
- Same run, memory model corrupts read data at address 0x110 -> err_cnt=1, first_err_addr=0x110, pass=0.
- cfg_bl=0, then cfg_bl=20 with BURST_MAX=8 -> bursts of 1 beat (cti=111 only) and 8 beats respectively.
- Base 0x3FFFFF8, 2 bursts, BL=4, mode 1, seed 0 -> address wraps to 0x0000000 at beat 2; LFSR starts from 1; pass=1.
- sdr_init_done held low for 500 cycles after start -> no cyc asserted; busy=1 throughout; traffic begins the cycle after init_done rises.
- Timeout feature defined, TIMEOUT_CYC=16, ack never returned -> timeout=1 and done=1 at cycle 16 of the stalled strobe; pass=0; cyc=0. A second run with responsive memory then passes.
